// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the requester and memory-side signals of the
// data-memory arbiter.
//   cpu_* / dbg_*  : request, write enable, address, write data in;
//                    completion pulse and registered read data out
//   mem_*          : single-cycle memory strobe, write enable, address,
//                    write data out; read data back from the memory
//   busy_o         : arbiter is not idle
// Modports: slave  = arbiter side
//           master = requesters plus memory (the environment)
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              cpu_req_i;
  logic              dbg_req_i;
  logic              cpu_we_i;
  logic              dbg_we_i;
  logic [DATA_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              cpu_done_o;
  logic              dbg_done_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;

  modport slave (
    input  cpu_req_i, dbg_req_i, cpu_we_i, dbg_we_i,
    input  cpu_addr_i, dbg_addr_i, cpu_wdata_i, dbg_wdata_i,
    output cpu_done_o, dbg_done_o, cpu_rdata_o, dbg_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport master (
    output cpu_req_i, dbg_req_i, cpu_we_i, dbg_we_i,
    output cpu_addr_i, dbg_addr_i, cpu_wdata_i, dbg_wdata_i,
    input  cpu_done_o, dbg_done_o, cpu_rdata_o, dbg_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU and a debug-dump port.
// One transaction at a time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE.
// Ties are resolved round-robin; the CPU wins the first tie after reset.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : dmem_arbiter_if.slave (requester and memory signals)
// Parameters:
//   DATA_W  : data/address width
//   MEM_LAT : memory read latency in cycles after the strobe (1..7)
module dmem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              any_req;
  logic              grant_dbg;
  logic              owner_dbg;
  logic              last_dbg;
  logic              lat_we;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic [2:0]        cnt;

  assign any_req = bus.cpu_req_i | bus.dbg_req_i;

  // Debug wins only when it is alone, or on a tie when the CPU was served last.
  assign grant_dbg = bus.dbg_req_i & (~bus.cpu_req_i | ~last_dbg);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_dbg <= 1'b0;
      last_dbg  <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_dbg <= grant_dbg;
            lat_we    <= grant_dbg ? bus.dbg_we_i    : bus.cpu_we_i;
            lat_addr  <= grant_dbg ? bus.dbg_addr_i  : bus.cpu_addr_i;
            lat_wdata <= grant_dbg ? bus.dbg_wdata_i : bus.cpu_wdata_i;
          end
        end
        ACCESS: begin
          cnt <= 3'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // Read data is valid during the last WAIT cycle only.
          if (cnt == 3'd1 && !lat_we) begin
            if (owner_dbg) begin
              dbg_rdata <= bus.mem_rdata_i;
            end else begin
              cpu_rdata <= bus.mem_rdata_i;
            end
          end
        end
        DONE: begin
          last_dbg <= owner_dbg;
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs are gated by ACCESS so they read as zero elsewhere,
  // including immediately on reset.
  assign bus.mem_en_o    = (state == ACCESS);
  assign bus.mem_we_o    = (state == ACCESS) & lat_we;
  assign bus.mem_addr_o  = (state == ACCESS) ? lat_addr  : '0;
  assign bus.mem_wdata_o = (state == ACCESS) ? lat_wdata : '0;

  assign bus.cpu_done_o  = (state == DONE) & ~owner_dbg;
  assign bus.dbg_done_o  = (state == DONE) &  owner_dbg;
  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.dbg_rdata_o = dbg_rdata;
  assign bus.busy_o      = (state != IDLE);

endmodule
